// File: rtl/hawk_mc_axi_responder.sv
// rtl/hawk_mc_axi_responder.sv - AXI4 slave backed by flop memory, standing in for the memory controller
// Independent write (AW/W/B) and read (AR/R) engines, one in-order burst each.
module hawk_mc_axi_responder #(
    parameter int                ADDR_W    = 64,
    parameter int                DATA_W    = 256,
    parameter int                ID_W      = 6,
    parameter int                MEM_AW    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awlock,
    input  logic [3:0]          s_axi_awcache,
    input  logic [2:0]          s_axi_awprot,
    input  logic [3:0]          s_axi_awqos,
    input  logic [3:0]          s_axi_awregion,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arlock,
    input  logic [3:0]          s_axi_arcache,
    input  logic [2:0]          s_axi_arprot,
    input  logic [3:0]          s_axi_arqos,
    input  logic [3:0]          s_axi_arregion,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);

    localparam int                STRB_W      = DATA_W / 8;
    localparam int                BSH         = $clog2(STRB_W);
    localparam int                DEPTH       = 1 << MEM_AW;
    localparam logic [ADDR_W-1:0] BEAT_BYTES  = ADDR_W'(STRB_W);
    localparam logic [1:0]        BURST_FIXED = 2'b00;
    localparam logic [1:0]        BURST_WRAP  = 2'b10;
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    function automatic logic beat_in_range(input logic [ADDR_W-1:0] a);
        return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> (MEM_AW + BSH)) == '0);
    endfunction

    function automatic logic [MEM_AW-1:0] beat_idx(input logic [ADDR_W-1:0] a);
        return MEM_AW'((a - BASE_ADDR) >> BSH);
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    w_state_e          w_state_q, w_state_d;
    logic [ID_W-1:0]   wid_q, wid_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [1:0]        wburst_q, wburst_d;
    logic              werr_q, werr_d;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_widx;

    r_state_e          r_state_q, r_state_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [1:0]        rburst_q, rburst_d;
    logic              rsize_err_q, rsize_err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rload;
    logic [ADDR_W-1:0] rload_addr;
    logic [1:0]        rload_burst;
    logic              rload_size_err;

    always_comb begin
        w_state_d = w_state_q;
        wid_d     = wid_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wburst_d  = wburst_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid) begin
                    wid_d     = s_axi_awid;
                    waddr_d   = s_axi_awaddr;
                    wlen_d    = s_axi_awlen;
                    wburst_d  = s_axi_awburst;
                    wcnt_d    = 8'd0;
                    werr_d    = (s_axi_awsize != 3'(BSH));
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid) begin
                    mem_we  = beat_in_range(waddr_q) && (wburst_q != BURST_WRAP);
                    werr_d  = werr_q | !mem_we | (s_axi_wlast != (wcnt_q == wlen_q));
                    waddr_d = (wburst_q == BURST_FIXED) ? waddr_q : waddr_q + BEAT_BYTES;
                    wcnt_d  = wcnt_q + 8'd1;
                    if (wcnt_q == wlen_q) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign mem_widx = beat_idx(waddr_q);

    // Memory holds its contents across reset; only the engines are cleared.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem_q[mem_widx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        r_state_d      = r_state_q;
        rid_d          = rid_q;
        raddr_d        = raddr_q;
        rlen_d         = rlen_q;
        rburst_d       = rburst_q;
        rsize_err_d    = rsize_err_q;
        rcnt_d         = rcnt_q;
        rdata_d        = rdata_q;
        rresp_d        = rresp_q;
        rload          = 1'b0;
        rload_addr     = raddr_q;
        rload_burst    = rburst_q;
        rload_size_err = rsize_err_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    rid_d          = s_axi_arid;
                    raddr_d        = s_axi_araddr;
                    rlen_d         = s_axi_arlen;
                    rburst_d       = s_axi_arburst;
                    rsize_err_d    = (s_axi_arsize != 3'(BSH));
                    rcnt_d         = 8'd0;
                    rload          = 1'b1;
                    rload_addr     = s_axi_araddr;
                    rload_burst    = s_axi_arburst;
                    rload_size_err = (s_axi_arsize != 3'(BSH));
                    r_state_d      = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    if (rcnt_q == rlen_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        rload      = 1'b1;
                        rload_addr = (rburst_q == BURST_FIXED) ? raddr_q : raddr_q + BEAT_BYTES;
                        raddr_d    = rload_addr;
                        rcnt_d     = rcnt_q + 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // A beat is loaded before the write of the same edge commits, so reads see old data.
        if (rload) begin
            if (beat_in_range(rload_addr) && (rload_burst != BURST_WRAP) && !rload_size_err) begin
                rdata_d = mem_q[beat_idx(rload_addr)];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q   <= W_IDLE;
            wid_q       <= '0;
            waddr_q     <= '0;
            wlen_q      <= '0;
            wburst_q    <= '0;
            wcnt_q      <= '0;
            werr_q      <= 1'b0;
            r_state_q   <= R_IDLE;
            rid_q       <= '0;
            raddr_q     <= '0;
            rlen_q      <= '0;
            rburst_q    <= '0;
            rsize_err_q <= 1'b0;
            rcnt_q      <= '0;
            rdata_q     <= '0;
            rresp_q     <= '0;
        end else begin
            w_state_q   <= w_state_d;
            wid_q       <= wid_d;
            waddr_q     <= waddr_d;
            wlen_q      <= wlen_d;
            wburst_q    <= wburst_d;
            wcnt_q      <= wcnt_d;
            werr_q      <= werr_d;
            r_state_q   <= r_state_d;
            rid_q       <= rid_d;
            raddr_q     <= raddr_d;
            rlen_q      <= rlen_d;
            rburst_q    <= rburst_d;
            rsize_err_q <= rsize_err_d;
            rcnt_q      <= rcnt_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
        end
    end

    assign s_axi_awready = (w_state_q == W_IDLE);
    assign s_axi_wready  = (w_state_q == W_DATA);
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bid     = wid_q;
    assign s_axi_bresp   = ((w_state_q == W_RESP) && werr_q) ? RESP_SLVERR : RESP_OKAY;

    assign s_axi_arready = (r_state_q == R_IDLE);
    assign s_axi_rvalid  = (r_state_q == R_DATA);
    assign s_axi_rlast   = (r_state_q == R_DATA) && (rcnt_q == rlen_q);
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    logic unused_sideband;
    assign unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                               s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion};

endmodule
